i2c_txn_arbiter: RTL and testbench

- Two-client arbiter and sequencer for the I2C master core (clk_50 domain).
- Grants the core to one requester at a time, round-robin.
- Loads the core's WR, address, sub_address and length; holds request; streams tx bytes into txReg and rx bytes out of rxReg on each DE rising edge; releases the core after the last byte.
- Sits between system clients (sensor poller, config writer) and the I2C core.

---
 rtl/i2c_txn_arbiter_if.sv | 51 +++++
 rtl/i2c_txn_arbiter.sv | 157 +++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_txn_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_txn_arbiter_if
// Description : Client-side and core-side signal bundle for the I2C
//               transaction arbiter. The master modport is the arbiter's view;
//               the slave modport is the clients'/core's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_txn_arbiter_if;
  // client side
  logic [1:0] c_req;
  logic [1:0] c_wr;
  logic [6:0] c_addr0;
  logic [6:0] c_addr1;
  logic [7:0] c_saddr0;
  logic [7:0] c_saddr1;
  logic [7:0] c_len0;
  logic [7:0] c_len1;
  logic [7:0] c_txd0;
  logic [7:0] c_txd1;
  logic [1:0] c_txpop;
  logic [7:0] c_rxd;
  logic [1:0] c_rxvld;
  logic [1:0] c_gnt;
  logic [1:0] c_done;
  logic [1:0] c_err;
  // core side
  logic       i2c_wr;
  logic [7:0] i2c_len;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_saddr;
  logic [7:0] i2c_tx;
  logic       i2c_req;
  logic [7:0] i2c_rx;
  logic       i2c_de;

  modport master (
    input  c_req, c_wr, c_addr0, c_addr1, c_saddr0, c_saddr1, c_len0, c_len1,
           c_txd0, c_txd1, i2c_rx, i2c_de,
    output c_txpop, c_rxd, c_rxvld, c_gnt, c_done, c_err,
           i2c_wr, i2c_len, i2c_addr, i2c_saddr, i2c_tx, i2c_req
  );

  modport slave (
    output c_req, c_wr, c_addr0, c_addr1, c_saddr0, c_saddr1, c_len0, c_len1,
           c_txd0, c_txd1, i2c_rx, i2c_de,
    input  c_txpop, c_rxd, c_rxvld, c_gnt, c_done, c_err,
           i2c_wr, i2c_len, i2c_addr, i2c_saddr, i2c_tx, i2c_req
  );
endinterface
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_txn_arbiter
// Description : Round-robin two-client arbiter and byte sequencer in front of
//               the I2C master core. Loads the core's transaction fields,
//               holds request, moves one byte per DE rising edge and enforces
//               a bus-free gap between transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_txn_arbiter #(
  parameter int GAP_CYCLES = 250,
  parameter int MAX_LEN    = 8
) (
  input  logic              clk_50,
  input  logic              rst_n,
  i2c_txn_arbiter_if.master bus
);

  localparam int              GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]      MAX_LEN_C = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           state_q;
  logic             rr_q;       // client with priority on the next tie
  logic             sel_q;      // currently granted client
  logic [7:0]       cnt_q;      // bytes completed in this transaction
  logic [GAP_W-1:0] gap_q;
  logic             de_q;

  logic [1:0] txpop_q, rxvld_q, gnt_q, done_q, err_q;
  logic [7:0] rxd_q;
  logic       wr_q, req_q;
  logic [7:0] len_q, saddr_q, tx_q;
  logic [6:0] addr_q;

  logic       pick;
  logic [7:0] pick_len, pick_txd, sel_txd, cnt_inc;
  logic       pick_bad, de_rise;

  // Candidate selection for IDLE and per-byte helpers for RUN.
  always_comb begin
    pick     = bus.c_req[rr_q] ? rr_q : ~rr_q;
    pick_len = pick ? bus.c_len1 : bus.c_len0;
    pick_txd = pick ? bus.c_txd1 : bus.c_txd0;
    pick_bad = (pick_len == 8'd0) || (pick_len > MAX_LEN_C);
    sel_txd  = sel_q ? bus.c_txd1 : bus.c_txd0;
    cnt_inc  = cnt_q + 8'd1;
    de_rise  = bus.i2c_de & ~de_q;
  end

  // Arbitration / sequencing FSM; every output is registered here.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      sel_q   <= 1'b0;
      cnt_q   <= 8'd0;
      gap_q   <= '0;
      de_q    <= 1'b0;
      txpop_q <= 2'b00;
      rxvld_q <= 2'b00;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      rxd_q   <= 8'd0;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      len_q   <= 8'd0;
      saddr_q <= 8'd0;
      tx_q    <= 8'd0;
      addr_q  <= 7'd0;
    end else begin
      de_q    <= bus.i2c_de;
      txpop_q <= 2'b00;
      rxvld_q <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (|bus.c_req) begin
            if (pick_bad) begin
              // Reject without touching the core; pass priority along so a
              // misbehaving client cannot starve the other one.
              err_q <= {pick, ~pick};
              rr_q  <= ~rr_q;
            end else begin
              sel_q   <= pick;
              wr_q    <= bus.c_wr[pick];
              addr_q  <= pick ? bus.c_addr1 : bus.c_addr0;
              saddr_q <= pick ? bus.c_saddr1 : bus.c_saddr0;
              len_q   <= pick_len;
              if (bus.c_wr[pick]) tx_q <= pick_txd;
              gnt_q   <= {pick, ~pick};
              cnt_q   <= 8'd0;
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // Byte 0 is already sitting in i2c_tx; let the client advance.
          if (wr_q) txpop_q <= {sel_q, ~sel_q};
          req_q   <= 1'b1;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (de_rise) begin
            cnt_q <= cnt_inc;
            if (wr_q) begin
              if (cnt_inc < len_q) begin
                tx_q    <= sel_txd;
                txpop_q <= {sel_q, ~sel_q};
              end
            end else begin
              rxd_q   <= bus.i2c_rx;
              rxvld_q <= {sel_q, ~sel_q};
            end
            if (cnt_inc == len_q) begin
              req_q   <= 1'b0;
              done_q  <= {sel_q, ~sel_q};
              gnt_q   <= 2'b00;
              rr_q    <= ~sel_q;
              gap_q   <= '0;
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) state_q <= S_IDLE;
          else gap_q <= gap_q + GAP_W'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.c_txpop   = txpop_q;
  assign bus.c_rxd     = rxd_q;
  assign bus.c_rxvld   = rxvld_q;
  assign bus.c_gnt     = gnt_q;
  assign bus.c_done    = done_q;
  assign bus.c_err     = err_q;
  assign bus.i2c_wr    = wr_q;
  assign bus.i2c_len   = len_q;
  assign bus.i2c_addr  = addr_q;
  assign bus.i2c_saddr = saddr_q;
  assign bus.i2c_tx    = tx_q;
  assign bus.i2c_req   = req_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_txn_arbiter
// Description : Directed self-checking bench for i2c_txn_arbiter with a small
//               client model and a core model pulsing DE every DE_N cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_arbiter;

  localparam int GAP  = 250;
  localparam int DE_N = 9;

  logic clk_50 = 1'b0;
  logic rst_n  = 1'b0;

  i2c_txn_arbiter_if bus ();

  i2c_txn_arbiter #(.GAP_CYCLES(GAP), .MAX_LEN(8)) dut (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #10 clk_50 = ~clk_50;

  int nerr = 0;
  int nchk = 0;

  logic [7:0] txbuf [2][8];
  logic [7:0] txlog [2][8];
  logic [7:0] rxlog [2][8];
  logic [7:0] rxbuf [8];
  int tx_idx [2];
  int pops [2];
  int nrx [2];
  int done_cnt [2];
  int err_cnt [2];
  int done_cyc [2];
  int gnt_log [8];
  int gnt_cyc [8];
  int ngnt = 0;
  int cyc = 0;
  int de_cnt = 0;
  int rx_idx = 0;
  int de_rises = 0;
  int req_at_done = 0;
  int rises_at_done = 0;
  int dual = 0;
  int busy_seen = 0;
  logic [1:0] prev_gnt = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_txd();
    bus.c_txd0 = txbuf[0][tx_idx[0]];
    bus.c_txd1 = txbuf[1][tx_idx[1]];
  endtask

  // One clock: sample DUT outputs #1 after the edge, update client and core models.
  task automatic tick();
    @(posedge clk_50);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (bus.c_txpop[k]) begin
        if (pops[k] < 8) txlog[k][pops[k]] = bus.i2c_tx;
        pops[k]++;
        if (tx_idx[k] < 7) tx_idx[k]++;
      end
      if (bus.c_rxvld[k]) begin
        if (nrx[k] < 8) rxlog[k][nrx[k]] = bus.c_rxd;
        nrx[k]++;
      end
      if (bus.c_done[k]) begin
        done_cnt[k]++;
        done_cyc[k]   = cyc;
        req_at_done   = int'(bus.i2c_req);
        rises_at_done = de_rises;
        bus.c_req[k]  = 1'b0;
      end
      if (bus.c_err[k]) begin
        err_cnt[k]++;
        bus.c_req[k] = 1'b0;
      end
    end
    drive_txd();
    if (bus.c_gnt != 2'b00 && prev_gnt == 2'b00 && ngnt < 8) begin
      gnt_log[ngnt] = bus.c_gnt[1] ? 1 : 0;
      gnt_cyc[ngnt] = cyc;
      ngnt++;
    end
    prev_gnt = bus.c_gnt;
    if (bus.c_gnt == 2'b11 || bus.c_done == 2'b11 || bus.c_err == 2'b11) dual++;
    if (bus.i2c_req || bus.c_gnt != 2'b00) busy_seen++;
    // core model: one-cycle DE every DE_N cycles while request is held
    if (bus.i2c_req) de_cnt++;
    else begin
      de_cnt = 0;
      rx_idx = 0;
    end
    if (bus.i2c_req && de_cnt != 0 && (de_cnt % DE_N) == 0) begin
      bus.i2c_rx = rxbuf[rx_idx < 8 ? rx_idx : 7];
      bus.i2c_de = 1'b1;
      rx_idx++;
      de_rises++;
    end else begin
      bus.i2c_de = 1'b0;
    end
  endtask

  task automatic setup(input int k, input logic wr, input logic [6:0] a,
                       input logic [7:0] sa, input logic [7:0] len);
    bus.c_wr[k] = wr;
    if (k == 0) begin
      bus.c_addr0 = a; bus.c_saddr0 = sa; bus.c_len0 = len;
    end else begin
      bus.c_addr1 = a; bus.c_saddr1 = sa; bus.c_len1 = len;
    end
    tx_idx[k] = 0;
    pops[k]   = 0;
    nrx[k]    = 0;
    de_rises  = 0;
    drive_txd();
  endtask

  task automatic wait_done(input int k, input string tag);
    int start;
    int n;
    start = done_cnt[k];
    n = 0;
    while (done_cnt[k] == start && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 32'(done_cnt[k] - start), 32'd1);
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    bus.c_req = 2'b00;
    bus.i2c_de = 1'b0;
    repeat (3) @(negedge clk_50);
    rst_n = 1'b1;
    prev_gnt = 2'b00;
    ngnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.c_req = 2'b00; bus.c_wr = 2'b00;
    bus.c_addr0 = '0; bus.c_addr1 = '0; bus.c_saddr0 = '0; bus.c_saddr1 = '0;
    bus.c_len0 = '0; bus.c_len1 = '0; bus.i2c_rx = '0; bus.i2c_de = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tx_idx[k] = 0; pops[k] = 0; nrx[k] = 0; done_cnt[k] = 0; err_cnt[k] = 0; done_cyc[k] = 0;
      for (int j = 0; j < 8; j++) begin
        txbuf[k][j] = 8'h00; txlog[k][j] = 8'h00; rxlog[k][j] = 8'h00;
      end
    end
    for (int j = 0; j < 8; j++) rxbuf[j] = 8'h00;
    drive_txd();
    do_reset();
    @(negedge clk_50);

    // reset state
    chk("rst_gnt", 32'(bus.c_gnt), 32'h0);
    chk("rst_req", 32'(bus.i2c_req), 32'h0);
    chk("rst_tx", 32'(bus.i2c_tx), 32'h0);
    chk("rst_pulses", 32'({bus.c_done, bus.c_err, bus.c_txpop, bus.c_rxvld}), 32'h0);

    // length rejects: client0 len 0, client1 len 9
    setup(0, 1'b0, 7'h10, 8'h00, 8'd0);
    setup(1, 1'b0, 7'h11, 8'h00, 8'd9);
    busy_seen = 0;
    bus.c_req = 2'b11;
    tick(); chk("err_first", 32'(bus.c_err), 32'h1);
    tick(); chk("err_second", 32'(bus.c_err), 32'h2);
    tick(); chk("err_quiet", 32'(bus.c_err), 32'h0);
    repeat (5) tick();
    chk("err_no_core", 32'(busy_seen), 32'd0);
    chk("err_counts", 32'(err_cnt[0] * 16 + err_cnt[1]), 32'h11);

    // single write, client0
    txbuf[0][0] = 8'h2A; txbuf[0][1] = 8'hEC;
    setup(0, 1'b1, 7'h1F, 8'hCC, 8'd2);
    bus.c_req[0] = 1'b1;
    tick();
    chk("wr_gnt", 32'(bus.c_gnt), 32'h1);
    chk("wr_fields", 32'({bus.i2c_wr, bus.i2c_addr, bus.i2c_saddr, bus.i2c_len}), 32'({1'b1, 7'h1F, 8'hCC, 8'd2}));
    chk("wr_tx0", 32'(bus.i2c_tx), 32'h2A);
    chk("wr_req_lat1", 32'(bus.i2c_req), 32'h0);
    tick();
    chk("wr_req_lat2", 32'(bus.i2c_req), 32'h1);
    chk("wr_pop0", 32'(bus.c_txpop), 32'h1);
    wait_done(0, "wr_done");
    chk("wr_pops", 32'(pops[0]), 32'd2);
    chk("wr_txlog", 32'({txlog[0][0], txlog[0][1]}), 32'h2AEC);
    chk("wr_req_drop", 32'(req_at_done), 32'd0);
    chk("wr_rises", 32'(rises_at_done), 32'd2);
    chk("wr_gnt_clr", 32'(bus.c_gnt), 32'h0);
    chk("wr_done_once", 32'(done_cnt[0]), 32'd1);

    // read, client1, len 3
    rxbuf[0] = 8'h11; rxbuf[1] = 8'h22; rxbuf[2] = 8'h33;
    setup(1, 1'b0, 7'h50, 8'h10, 8'd3);
    bus.c_req[1] = 1'b1;
    wait_done(1, "rd_done");
    chk("rd_count", 32'(nrx[1]), 32'd3);
    chk("rd_data", 32'({rxlog[1][0], rxlog[1][1], rxlog[1][2]}), 32'h112233);
    chk("rd_other", 32'(nrx[0]), 32'd0);

    // simultaneous requests from reset; order 0,1,0,1
    do_reset();
    rxbuf[0] = 8'h5C;
    setup(0, 1'b0, 7'h01, 8'h00, 8'd1);
    setup(1, 1'b0, 7'h02, 8'h00, 8'd1);
    bus.c_req = 2'b11;
    wait_done(0, "rr_done0a");
    wait_done(1, "rr_done1a");
    chk("rr_gap", 32'(gnt_cyc[1] - done_cyc[0]), 32'(GAP + 1));
    repeat (GAP + 2) tick();
    bus.c_req = 2'b11;
    wait_done(0, "rr_done0b");
    wait_done(1, "rr_done1b");
    chk("rr_order", 32'({gnt_log[0][3:0], gnt_log[1][3:0], gnt_log[2][3:0], gnt_log[3][3:0]}), 32'h0101);
    chk("rr_ngnt", 32'(ngnt), 32'd4);

    // reset mid-RUN after one de_rise
    repeat (GAP + 2) tick();
    txbuf[0][0] = 8'h01; txbuf[0][1] = 8'h02; txbuf[0][2] = 8'h03;
    setup(0, 1'b1, 7'h33, 8'h44, 8'd3);
    bus.c_req[0] = 1'b1;
    n = 0;
    while (de_rises < 1 && n < 500) begin tick(); n++; end
    tick(); tick();
    chk("mid_req_pre", 32'(bus.i2c_req), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'({bus.c_gnt, bus.i2c_req, bus.i2c_wr, bus.i2c_len, bus.i2c_addr}), 32'h0);
    chk("mid_rst_tx", 32'({bus.i2c_tx, bus.i2c_saddr}), 32'h0);
    bus.c_req = 2'b00;
    n = done_cnt[0];
    @(negedge clk_50);
    @(negedge clk_50);
    rst_n = 1'b1;
    prev_gnt = 2'b00;
    repeat (3) tick();
    chk("mid_no_done", 32'(done_cnt[0] - n), 32'd0);
    setup(0, 1'b0, 7'h05, 8'h00, 8'd1);
    setup(1, 1'b0, 7'h06, 8'h00, 8'd1);
    bus.c_req = 2'b11;
    tick();
    chk("mid_after_gnt", 32'(bus.c_gnt), 32'h1);
    wait_done(0, "mid_done0");
    wait_done(1, "mid_done1");

    // client0 drops request mid-transfer
    txbuf[0][0] = 8'h5A; txbuf[0][1] = 8'hA5; txbuf[0][2] = 8'h3C;
    setup(0, 1'b1, 7'h21, 8'h02, 8'd3);
    bus.c_req[0] = 1'b1;
    n = 0;
    while (de_rises < 1 && n < 2000) begin tick(); n++; end
    bus.c_req[0] = 1'b0;
    wait_done(0, "drop_done");
    chk("drop_pops", 32'(pops[0]), 32'd3);
    chk("drop_txlog", 32'({txlog[0][0], txlog[0][1], txlog[0][2]}), 32'h5AA53C);

    chk("never_dual", 32'(dual), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
